// File: rtl/ram_pkg.sv
// Shared types for the synchronous clearable RAM.
// Holds the clear-sequencer state encoding used by ram_sync_clr.
package ram_pkg;

  typedef enum logic {
    RAM_IDLE  = 1'b0,
    RAM_CLEAR = 1'b1
  } ram_state_e;

endpackage

// File: rtl/ram_core.sv
// Bare storage array: synchronous write port, combinational read port.
// Contents are never reset; the clear sweep in the top level initialises them.
module ram_core #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // The registered read stage lives in the top so the write-first bypass sits beside it.
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/ram_sync_clr.sv
// Parametrised synchronous RAM with chip-style active-low controls, registered
// write-first reads and a hardware sweep that writes CLEAR_VAL to every location.
module ram_sync_clr
  import ram_pkg::*;
#(
  parameter int unsigned   AW         = 8,
  parameter int unsigned   DW         = 4,
  parameter logic [DW-1:0] CLEAR_VAL  = '0,
  parameter bit            INIT_CLEAR = 1'b1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-1:0] a,
  input  logic [DW-1:0] i,
  output logic [DW-1:0] d,
  input  logic          cs1_n,
  input  logic          cs2,
  input  logic          oe_n,
  input  logic          w_n,
  input  logic          clear_req,
  output logic          busy
);

  localparam ram_state_e    StReset = INIT_CLEAR ? RAM_CLEAR : RAM_IDLE;
  localparam logic [AW-1:0] CntOne  = AW'(1);

  ram_state_e    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] dq_q, dq_d;

  logic          en;
  logic          user_we;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  assign busy    = (state_q == RAM_CLEAR);
  assign en      = ~cs1_n & cs2 & ~busy;
  assign user_we = en & ~w_n;

  // Clear sequencer: one location per edge, terminating on counter wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RAM_IDLE: begin
        if (clear_req) begin
          state_d = RAM_CLEAR;
          cnt_d   = '0;
        end
      end
      RAM_CLEAR: begin
        cnt_d = cnt_q + CntOne;
        if (cnt_q == {AW{1'b1}}) begin
          state_d = RAM_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StReset;
        cnt_d   = '0;
      end
    endcase
  end

  // Write port is owned by the sweep while busy, otherwise by the user.
  always_comb begin
    mem_we    = user_we;
    mem_waddr = a;
    mem_wdata = i;
    if (busy) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wdata = CLEAR_VAL;
    end
  end

  always_comb begin
    dq_d = dq_q;
    if (en) begin
      dq_d = w_n ? mem_rdata : i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StReset;
      cnt_q   <= '0;
      dq_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dq_q    <= dq_d;
    end
  end

  ram_core #(
    .AW (AW),
    .DW (DW)
  ) u_core (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (a),
    .rdata (mem_rdata)
  );

  assign d = oe_n ? '0 : dq_q;

endmodule

// File: tb/tb_ram_sync_clr.sv
// Self-checking bench for ram_sync_clr: directed table, sweep-length sequences
// and randomized traffic compared against a behavioural model.
module tb_ram_sync_clr;

  localparam logic [3:0] CV    = 4'hA;
  localparam int         DEPTH = 256;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] a;
  logic [3:0] i;
  logic [3:0] d;
  logic       cs1_n, cs2, oe_n, w_n, clear_req;
  logic       busy;

  int vecs = 0;
  int errs = 0;

  // Reference model state
  logic [3:0] mem_m [DEPTH];
  logic [3:0] dq_m;
  logic       busy_m;
  int         left_m;

  typedef struct {
    logic       cs1_n;
    logic       cs2;
    logic       oe_n;
    logic       w_n;
    logic [7:0] a;
    logic [3:0] i;
    logic [3:0] exp_d;
  } vec_t;

  vec_t tbl [12];

  ram_sync_clr #(
    .AW         (8),
    .DW         (4),
    .CLEAR_VAL  (CV),
    .INIT_CLEAR (1'b1)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .a         (a),
    .i         (i),
    .d         (d),
    .cs1_n     (cs1_n),
    .cs2       (cs2),
    .oe_n      (oe_n),
    .w_n       (w_n),
    .clear_req (clear_req),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    dq_m   = '0;
    busy_m = 1'b1;
    left_m = DEPTH;
  endtask

  task automatic model_edge();
    bit en;
    en = !cs1_n && cs2 && !busy_m;
    if (en) begin
      if (!w_n) begin
        mem_m[a] = i;
        dq_m     = i;
      end else begin
        dq_m = mem_m[a];
      end
    end
    if (busy_m) begin
      mem_m[DEPTH - left_m] = CV;
      left_m--;
      if (left_m == 0) busy_m = 1'b0;
    end else if (clear_req) begin
      busy_m = 1'b1;
      left_m = DEPTH;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("d", int'(d), oe_n ? 0 : int'(dq_m));
    chk("busy", int'(busy), int'(busy_m));
  endtask

  task automatic idle();
    cs1_n = 1'b1; cs2 = 1'b0; oe_n = 1'b0; w_n = 1'b1; clear_req = 1'b0;
  endtask

  task automatic drive(input logic c1, input logic c2, input logic oe, input logic wn,
                       input logic [7:0] ad, input logic [3:0] dat);
    cs1_n = c1; cs2 = c2; oe_n = oe; w_n = wn; a = ad; i = dat;
  endtask

  // Counts edges until busy drops; mode 1 injects a write mid-sweep, mode 2 a clear_req.
  task automatic sweep_len(input int mode);
    int n;
    n = 0;
    do begin
      if (mode == 1 && n == 100) drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h05, 4'hF);
      if (mode == 2 && n == 50) clear_req = 1'b1;
      step();
      idle();
      n++;
    end while (busy && n < 400);
    chk("sweep_len", n, DEPTH);
  endtask

  initial begin
    reset_n = 1'b0;
    a = '0; i = '0;
    idle();
    model_reset();

    tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 4'h0, CV};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h7F, 4'h0, CV};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'hFF, 4'h0, CV};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h05, 4'h0, CV};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h12, 4'h5, 4'h5};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h12, 4'h0, 4'h5};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h12, 4'h0, 4'h0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h40, 4'h3, 4'h3};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h12, 4'hF, 4'h3};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h12, 4'hF, 4'h3};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h12, 4'h0, 4'h5};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h40, 4'h0, 4'h3};

    #12;
    chk("reset_d", int'(d), 0);
    chk("reset_busy", int'(busy), 1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Power-up sweep, with a write attempted while busy
    sweep_len(1);

    for (int k = 0; k < 12; k++) begin
      drive(tbl[k].cs1_n, tbl[k].cs2, tbl[k].oe_n, tbl[k].w_n, tbl[k].a, tbl[k].i);
      step();
      chk($sformatf("tbl%0d", k), int'(d), int'(tbl[k].exp_d));
    end

    // Fill with low nibble, then clear with a coincident write and a repeat request
    for (int k = 0; k < DEPTH; k++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 8'(k), 4'(k));
      step();
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'h7);
    clear_req = 1'b1;
    step();
    idle();
    chk("req_busy", int'(busy), 1);
    sweep_len(2);
    for (int k = 0; k < DEPTH; k++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b1, 8'(k), 4'h0);
      step();
      if (k % 32 == 0 || k == DEPTH - 1) chk($sformatf("clr_rd%0h", k), int'(d), int'(CV));
    end

    // Reset in the middle of a requested sweep
    idle();
    clear_req = 1'b1;
    step();
    idle();
    for (int k = 0; k < 99; k++) step();
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_d", int'(d), 0);
    chk("midrst_busy", int'(busy), 1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    sweep_len(0);

    // Randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      drive(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)),
            8'($urandom_range(0, 31)), 4'($urandom));
      clear_req = 1'($urandom_range(0, 149) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
